stack_ptr_unit: RTL and testbench
=================================

Name: stack_ptr_unit

Overview:
- Holds the main-stack pointer (MSP) and return-stack pointer (RSP) for the stack CPU.
- Consumes the multi-cycle controller's MSPop/MSPWrite and RSPop/RSPWrite strobes.
- Drives the stack word addresses used by the memory-address muxes: top of stack, second element and next free slot.
- With bounds checking compiled in, tracks stack depth and flags overflow and underflow.

Parameters:
- ADDR_W, 16, width of a word address and of each pointer.
- MS_BASE, 16'hFFFF, reset value of MSP; the main stack occupies the MS_DEPTH words ending at MS_BASE.
- MS_DEPTH, 256, maximum main-stack depth in words.
- RS_BASE, 16'hFEFF, reset value of RSP; the return stack occupies the RS_DEPTH words ending at RS_BASE.
- RS_DEPTH, 64, maximum return-stack depth in words.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ms_pop  in  1  MSP direction: 1 = pop (MSP+1), 0 = push (MSP-1); sampled only when ms_we=1
- ms_we  in  1  MSP update enable (controller MSPWrite)
- rs_pop  in  1  RSP direction, same encoding as ms_pop (controller RSPop)
- rs_we  in  1  RSP update enable (controller RSPWrite)
- err_clr  in  1  synchronous clear of the sticky error flags
- ms_free_addr  out  ADDR_W  MSP (next free main-stack slot)
- ms_top_addr  out  ADDR_W  MSP+1 (top of stack)
- ms_sec_addr  out  ADDR_W  MSP+2 (second element)
- rs_free_addr  out  ADDR_W  RSP
- rs_top_addr  out  ADDR_W  RSP+1
- ms_empty  out  1  main-stack depth == 0
- ms_full  out  1  main-stack depth == MS_DEPTH
- rs_empty  out  1  return-stack depth == 0
- rs_full  out  1  return-stack depth == RS_DEPTH
- ms_err  out  1  sticky main-stack overflow or underflow
- rs_err  out  1  sticky return-stack overflow or underflow

Behaviour:
- Stack organisation:
  - Both stacks are empty-descending: the pointer names the next free slot.
  - A push decrements the pointer; a pop increments it.
- Reset (rst=0, asynchronous):
  - MSP=MS_BASE, RSP=RS_BASE; both depth counters 0; ms_err=rs_err=0.
  - Resulting outputs: ms_free_addr=FFFF, ms_top_addr=0000, ms_sec_addr=0001, rs_free_addr=FEFF, rs_top_addr=FF00.
  - ms_empty=rs_empty=1, ms_full=rs_full=0.
  - Reset asserted mid-sequence discards any pending update.
- Update timing:
  - A pointer updates on the rising clk edge where its we=1.
  - All address and status outputs are combinational from registered state, so a new value is visible in the cycle after the strobe. Latency is 1 clock.
  - we=0 holds the pointer; the pop input is then ignored.
- MSP and RSP are fully independent. Simultaneous ms_we and rs_we in one cycle both update (jpush case).
- Arithmetic: all address adds are modulo 2^ADDR_W (FFFF+1=0000).
- Depth counters:
  - Width is clog2(DEPTH+1).
  - A counter increments on push and decrements on pop, in lockstep with its pointer.
- Boundary conditions:
  - Push while full, or pop while empty, is handled per the Optional Feature.
  - err_clr=1 clears both error flags at the clock edge.
  - A new error in the same cycle as err_clr wins: the flag is set.
- The block has no internal state machine beyond the two pointer/depth register pairs.
- No handshake: the controller guarantees at most one update per stack per cycle.

Optional Feature:
- Macro: STACK_BOUNDS_CHECK_EN.
- Defined:
  - Push at full or pop at empty is suppressed: pointer and depth hold.
  - The matching *_err flag sets and stays set until err_clr or reset.
- Undefined:
  - Depth counters and error logic are removed.
  - Pointers move unconditionally and wrap modulo 2^ADDR_W.
  - ms_empty, ms_full, rs_empty, rs_full, ms_err and rs_err are tied to 0.

Test Plan:
1. Release reset, then 3 ms pushes (ms_we=1, ms_pop=0) -> ms_free_addr=FFFC, ms_top_addr=FFFD, ms_sec_addr=FFFE, ms_empty=0.
2. Same cycle ms_we=1/ms_pop=1 and rs_we=1/rs_pop=0 -> next cycle MSP=FFFD and RSP=FEFE; both change together.
3. Pop on empty main stack with STACK_BOUNDS_CHECK_EN -> MSP stays FFFF and ms_err=1 next cycle. Without the macro -> MSP=0000 and ms_err=0.
4. 64 rs pushes -> rs_full=1, RSP=FEBF. 65th push with the macro -> RSP holds FEBF and rs_err=1.
5. err_clr=1 with rs_err=1 and no new error -> rs_err=0 next cycle. err_clr=1 together with an overflowing push -> rs_err stays 1.
6. 5 ms pushes, then rst=0 pulsed asynchronously between clock edges -> ms_free_addr=FFFF and ms_empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stack_ptr_unit.sv
// Main-stack and return-stack pointers for the stack CPU, with stack address taps.
// Define STACK_BOUNDS_CHECK_EN to add depth tracking, overflow/underflow suppression and error flags.
module stack_ptr_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] MS_BASE  = 16'hFFFF,
    parameter int unsigned       MS_DEPTH = 256,
    parameter logic [ADDR_W-1:0] RS_BASE  = 16'hFEFF,
    parameter int unsigned       RS_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ms_pop,
    input  logic              ms_we,
    input  logic              rs_pop,
    input  logic              rs_we,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] ms_free_addr,
    output logic [ADDR_W-1:0] ms_top_addr,
    output logic [ADDR_W-1:0] ms_sec_addr,
    output logic [ADDR_W-1:0] rs_free_addr,
    output logic [ADDR_W-1:0] rs_top_addr,
    output logic              ms_empty,
    output logic              ms_full,
    output logic              rs_empty,
    output logic              rs_full,
    output logic              ms_err,
    output logic              rs_err
);

    logic [ADDR_W-1:0] msp_q, msp_d;
    logic [ADDR_W-1:0] rsp_q, rsp_d;

    // Empty-descending: pointer is the next free slot, so the top sits one word above it.
    always_comb begin
        ms_free_addr = msp_q;
        ms_top_addr  = msp_q + ADDR_W'(1);
        ms_sec_addr  = msp_q + ADDR_W'(2);
        rs_free_addr = rsp_q;
        rs_top_addr  = rsp_q + ADDR_W'(1);
    end

`ifdef STACK_BOUNDS_CHECK_EN
    localparam int unsigned MsDepthW = $clog2(MS_DEPTH + 1);
    localparam int unsigned RsDepthW = $clog2(RS_DEPTH + 1);

    logic [MsDepthW-1:0] ms_depth_q, ms_depth_d;
    logic [RsDepthW-1:0] rs_depth_q, rs_depth_d;
    logic                ms_err_q, ms_err_d;
    logic                rs_err_q, rs_err_d;
    logic                ms_bad, rs_bad;

    always_comb begin
        ms_empty = (ms_depth_q == '0);
        ms_full  = (ms_depth_q == MsDepthW'(MS_DEPTH));
        rs_empty = (rs_depth_q == '0);
        rs_full  = (rs_depth_q == RsDepthW'(RS_DEPTH));
        ms_err   = ms_err_q;
        rs_err   = rs_err_q;

        ms_bad = ms_we & (ms_pop ? ms_empty : ms_full);
        rs_bad = rs_we & (rs_pop ? rs_empty : rs_full);

        msp_d      = msp_q;
        ms_depth_d = ms_depth_q;
        if (ms_we && !ms_bad) begin
            msp_d      = ms_pop ? msp_q + ADDR_W'(1) : msp_q - ADDR_W'(1);
            ms_depth_d = ms_pop ? ms_depth_q - MsDepthW'(1) : ms_depth_q + MsDepthW'(1);
        end

        rsp_d      = rsp_q;
        rs_depth_d = rs_depth_q;
        if (rs_we && !rs_bad) begin
            rsp_d      = rs_pop ? rsp_q + ADDR_W'(1) : rsp_q - ADDR_W'(1);
            rs_depth_d = rs_pop ? rs_depth_q - RsDepthW'(1) : rs_depth_q + RsDepthW'(1);
        end

        // A fresh error outranks a simultaneous clear.
        ms_err_d = (ms_err_q & ~err_clr) | ms_bad;
        rs_err_d = (rs_err_q & ~err_clr) | rs_bad;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_depth_q <= '0;
            rs_depth_q <= '0;
            ms_err_q   <= 1'b0;
            rs_err_q   <= 1'b0;
        end else begin
            ms_depth_q <= ms_depth_d;
            rs_depth_q <= rs_depth_d;
            ms_err_q   <= ms_err_d;
            rs_err_q   <= rs_err_d;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    always_comb begin
        ms_empty = 1'b0;
        ms_full  = 1'b0;
        rs_empty = 1'b0;
        rs_full  = 1'b0;
        ms_err   = 1'b0;
        rs_err   = 1'b0;

        msp_d = msp_q;
        if (ms_we) begin
            msp_d = ms_pop ? msp_q + ADDR_W'(1) : msp_q - ADDR_W'(1);
        end

        rsp_d = rsp_q;
        if (rs_we) begin
            rsp_d = rs_pop ? rsp_q + ADDR_W'(1) : rsp_q - ADDR_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msp_q <= MS_BASE;
            rsp_q <= RS_BASE;
        end else begin
            msp_q <= msp_d;
            rsp_q <= rsp_d;
        end
    end

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Directed self-checking bench for stack_ptr_unit; expectations follow STACK_BOUNDS_CHECK_EN.
module tb_stack_ptr_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ms_pop = 1'b0, ms_we = 1'b0, rs_pop = 1'b0, rs_we = 1'b0, err_clr = 1'b0;
    logic [15:0] ms_free_addr, ms_top_addr, ms_sec_addr, rs_free_addr, rs_top_addr;
    logic        ms_empty, ms_full, rs_empty, rs_full, ms_err, rs_err;

    int errors = 0;
    int checks = 0;

`ifdef STACK_BOUNDS_CHECK_EN
    localparam logic Bc = 1'b1;
`else
    localparam logic Bc = 1'b0;
`endif

    stack_ptr_unit dut (
        .clk          (clk),
        .rst          (rst),
        .ms_pop       (ms_pop),
        .ms_we        (ms_we),
        .rs_pop       (rs_pop),
        .rs_we        (rs_we),
        .err_clr      (err_clr),
        .ms_free_addr (ms_free_addr),
        .ms_top_addr  (ms_top_addr),
        .ms_sec_addr  (ms_sec_addr),
        .rs_free_addr (rs_free_addr),
        .rs_top_addr  (rs_top_addr),
        .ms_empty     (ms_empty),
        .ms_full      (ms_full),
        .rs_empty     (rs_empty),
        .rs_full      (rs_full),
        .ms_err       (ms_err),
        .rs_err       (rs_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes, then strobes drop and outputs settle.
    task automatic cyc(input logic mwe, input logic mpop, input logic rwe, input logic rpop,
                       input logic clr);
        ms_we = mwe; ms_pop = mpop; rs_we = rwe; rs_pop = rpop; err_clr = clr;
        @(posedge clk);
        #1;
        ms_we = 1'b0; ms_pop = 1'b0; rs_we = 1'b0; rs_pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ms_free", ms_free_addr, 16'hFFFF);
        check("rst_ms_top",  ms_top_addr,  16'h0000);
        check("rst_ms_sec",  ms_sec_addr,  16'h0001);
        check("rst_rs_free", rs_free_addr, 16'hFEFF);
        check("rst_rs_top",  rs_top_addr,  16'hFF00);
        check("rst_flags", {10'd0, ms_empty, rs_empty, ms_full, rs_full, ms_err, rs_err},
              {10'd0, Bc, Bc, 4'b0000});

        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("push3_free",  ms_free_addr, 16'hFFFC);
        check("push3_top",   ms_top_addr,  16'hFFFD);
        check("push3_sec",   ms_sec_addr,  16'hFFFE);
        check("push3_empty", {15'd0, ms_empty}, 16'h0000);

        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("we0_hold_ms", ms_free_addr, 16'hFFFC);
        check("we0_hold_rs", rs_free_addr, 16'hFEFF);

        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("jpush_msp", ms_free_addr, 16'hFFFD);
        check("jpush_rsp", rs_free_addr, 16'hFEFE);
        check("jpush_rs_top", rs_top_addr, 16'hFEFF);

        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pop_to_base", ms_free_addr, 16'hFFFF);
        check("pop_to_base_empty", {15'd0, ms_empty}, {15'd0, Bc});

        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("underflow_msp", ms_free_addr, Bc ? 16'hFFFF : 16'h0000);
        check("underflow_top", ms_top_addr,  Bc ? 16'h0000 : 16'h0001);
        check("underflow_err", {15'd0, ms_err}, {15'd0, Bc});
        if (!Bc) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ms_back_base", ms_free_addr, 16'hFFFF);

        repeat (63) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rs_full_rsp", rs_free_addr, 16'hFEBF);
        check("rs_full_flag", {15'd0, rs_full}, {15'd0, Bc});
        check("rs_full_err", {15'd0, rs_err}, 16'h0000);

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rs_ovf_rsp", rs_free_addr, Bc ? 16'hFEBF : 16'hFEBE);
        check("rs_ovf_err", {15'd0, rs_err}, {15'd0, Bc});

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_rs_err", {15'd0, rs_err}, 16'h0000);
        check("clr_ms_err", {15'd0, ms_err}, 16'h0000);

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_vs_ovf_err", {15'd0, rs_err}, {15'd0, Bc});
        check("clr_vs_ovf_rsp", rs_free_addr, Bc ? 16'hFEBF : 16'hFEBD);

        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("push5_msp", ms_free_addr, 16'hFFFA);

        #2 rst = 1'b0;
        #1;
        check("async_rst_msp", ms_free_addr, 16'hFFFF);
        check("async_rst_empty", {15'd0, ms_empty}, {15'd0, Bc});
        check("async_rst_rsp", rs_free_addr, 16'hFEFF);
        check("async_rst_err", {15'd0, rs_err}, 16'h0000);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_hold", ms_free_addr, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
